// File: rtl/dco_sw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dco_sw_ctrl
// Description : LC-DCO capacitor-bank switch controller. Turns single-cycle
//               frequency-correction pulses from the acquisition loop into a
//               saturating capacitor count and a registered thermometer
//               switch word. After every accepted correction it holds off for
//               a settle window so the DCO and counters can respond.
// Ports       : ref_clk        - sole clock
//               reset          - synchronous, active-high reset
//               freq_update    - single-cycle correction request
//               freq_incr_decr - 1 = raise frequency (remove caps),
//                                0 = lower frequency (add caps)
//               fll_locked     - 1 = fine step (1), 0 = coarse step
//               sw             - thermometer switch word, sw[i] = (i < sw_code)
//               sw_code        - capacitor count, 0..NSW
//               busy           - high while settling
//               at_min/at_max  - count at 0 / at NSW
//               sat_hit        - one-cycle pulse when an update was clipped
//               drop_cnt       - saturating count of updates ignored while busy
// Revision    : 1.0 - initial release
// ============================================================================
module dco_sw_ctrl #(
    parameter int NSW         = 32,
    parameter int INIT_CODE   = 16,
    parameter int STEP_COARSE = 4,
    parameter int SETTLE_CYC  = 8,
    localparam int CW         = $clog2(NSW + 1)
) (
    input  logic          ref_clk,
    input  logic          reset,
    input  logic          freq_update,
    input  logic          freq_incr_decr,
    input  logic          fll_locked,
    output logic [NSW-1:0] sw,
    output logic [CW-1:0] sw_code,
    output logic          busy,
    output logic          at_min,
    output logic          at_max,
    output logic          sat_hit,
    output logic [7:0]    drop_cnt
);

    localparam int TW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    // Thermometer decode of a count; only ever used to feed a register.
    function automatic logic [NSW-1:0] f_therm(input logic [CW:0] code);
        logic [NSW-1:0] t;
        for (int i = 0; i < NSW; i++) begin
            t[i] = (i < int'(code));
        end
        return t;
    endfunction

    localparam logic [CW:0]    c_nsw         = (CW+1)'(NSW);
    localparam logic [CW:0]    c_step_coarse = (CW+1)'(STEP_COARSE);
    localparam logic [CW:0]    c_step_fine   = (CW+1)'(1);
    localparam logic [TW-1:0]  c_timer_load  = TW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0]  c_init_code   = CW'(INIT_CODE);
    localparam logic [NSW-1:0] c_init_sw     = f_therm((CW+1)'(INIT_CODE));

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [TW-1:0]  r_timer;
    logic [TW-1:0]  w_timer_nxt;
    logic           w_accept;
    logic           w_drop;

    logic [CW-1:0]  r_code;
    logic [NSW-1:0] r_sw;
    logic           r_busy;
    logic           r_at_min;
    logic           r_at_max;
    logic           r_sat_hit;
    logic [7:0]     r_drop_cnt;

    logic [CW:0]    w_step;
    logic [CW:0]    w_code_ext;
    logic [CW:0]    w_sum;
    logic [CW:0]    w_calc;
    logic           w_clip;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (freq_update) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SETTLE;
                    w_timer_nxt = c_timer_load;
                end
            end
            ST_SETTLE: begin
                // Requests are ignored for the whole window, including the
                // edge on which the timer expires.
                w_drop = freq_update;
                if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Step and clip; one extra bit of headroom so nothing wraps.
    // ------------------------------------------------------------------
    always_comb begin
        w_step     = fll_locked ? c_step_fine : c_step_coarse;
        w_code_ext = {1'b0, r_code};
        w_sum      = w_code_ext + w_step;
        w_calc     = w_code_ext;
        w_clip     = 1'b0;
        if (freq_incr_decr) begin
            if (w_code_ext >= w_step) begin
                w_calc = w_code_ext - w_step;
            end else begin
                w_calc = '0;
                w_clip = 1'b1;
            end
        end else begin
            if (w_sum <= c_nsw) begin
                w_calc = w_sum;
            end else begin
                w_calc = c_nsw;
                w_clip = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_code     <= c_init_code;
            r_sw       <= c_init_sw;
            r_busy     <= 1'b0;
            r_at_min   <= (INIT_CODE == 0);
            r_at_max   <= (INIT_CODE == NSW);
            r_sat_hit  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_busy    <= (w_state_nxt == ST_SETTLE);
            r_sat_hit <= w_accept & w_clip;
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_accept) begin
                r_code   <= w_calc[CW-1:0];
                r_sw     <= f_therm(w_calc);
                r_at_min <= (w_calc == '0);
                r_at_max <= (w_calc == c_nsw);
            end
        end
    end

    assign sw       = r_sw;
    assign sw_code  = r_code;
    assign busy     = r_busy;
    assign at_min   = r_at_min;
    assign at_max   = r_at_max;
    assign sat_hit  = r_sat_hit;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dco_sw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dco_sw_ctrl
// Description : Self-checking bench for dco_sw_ctrl. Directed vector table
//               followed by a random phase checked against a behavioural
//               model; expectations flow through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dco_sw_ctrl;

    localparam int NSW = 32;
    localparam int CW  = 6;

    logic           ref_clk = 1'b0;
    logic           reset = 1'b1;
    logic           freq_update = 1'b0;
    logic           freq_incr_decr = 1'b0;
    logic           fll_locked = 1'b0;
    logic [NSW-1:0] sw;
    logic [CW-1:0]  sw_code;
    logic           busy;
    logic           at_min;
    logic           at_max;
    logic           sat_hit;
    logic [7:0]     drop_cnt;

    dco_sw_ctrl #(
        .NSW        (32),
        .INIT_CODE  (16),
        .STEP_COARSE(4),
        .SETTLE_CYC (8)
    ) dut (
        .ref_clk       (ref_clk),
        .reset         (reset),
        .freq_update   (freq_update),
        .freq_incr_decr(freq_incr_decr),
        .fll_locked    (fll_locked),
        .sw            (sw),
        .sw_code       (sw_code),
        .busy          (busy),
        .at_min        (at_min),
        .at_max        (at_max),
        .sat_hit       (sat_hit),
        .drop_cnt      (drop_cnt)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        bit rst;
        bit upd;
        bit dir;
        bit lk;
        int code;
        bit bsy;
        bit sat;
        int drop;
    } vec_t;

    typedef struct {
        int code;
        bit bsy;
        bit sat;
        int drop;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // behavioural model state for the random phase
    int m_code, m_left, m_drop;
    bit m_sat;

    task automatic vec(input bit rst, input bit upd, input bit dir, input bit lk,
                       input int code, input bit bsy, input bit sat, input int drop);
        vec_t v;
        v.rst = rst; v.upd = upd; v.dir = dir; v.lk = lk;
        v.code = code; v.bsy = bsy; v.sat = sat; v.drop = drop;
        tbl.push_back(v);
    endtask

    // Rows after an accepted update: 7 more busy edges, then busy drops.
    task automatic settle(input int code, input int drop);
        for (int i = 0; i < 7; i++) vec(0, 0, 0, 0, code, 1, 0, drop);
        vec(0, 0, 0, 0, code, 0, 0, drop);
    endtask

    task automatic cmp(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_out(input exp_t e);
        logic [NSW-1:0] e_sw;
        for (int i = 0; i < NSW; i++) e_sw[i] = (i < e.code);
        cmp("sw_code", int'(sw_code), e.code);
        total++;
        if (sw !== e_sw) begin
            bad++;
            $display("FAIL sw: got %h expected %h (t=%0t)", sw, e_sw, $time);
        end
        cmp("busy", int'(busy), int'(e.bsy));
        cmp("at_min", int'(at_min), int'(e.code == 0));
        cmp("at_max", int'(at_max), int'(e.code == NSW));
        cmp("sat_hit", int'(sat_hit), int'(e.sat));
        cmp("drop_cnt", int'(drop_cnt), e.drop);
    endtask

    // Drive one cycle of inputs, then pop the expectation and compare.
    task automatic apply(input bit rst, input bit upd, input bit dir, input bit lk);
        exp_t e;
        @(negedge ref_clk);
        reset = rst; freq_update = upd; freq_incr_decr = dir; fll_locked = lk;
        @(posedge ref_clk);
        #1;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            check_out(e);
        end
    endtask

    task automatic model_step(input bit rst, input bit upd, input bit dir, input bit lk);
        int s, t;
        exp_t e;
        m_sat = 0;
        if (rst) begin
            m_code = 16; m_left = 0; m_drop = 0;
        end else if (m_left == 0) begin
            if (upd) begin
                s = lk ? 1 : 4;
                t = dir ? m_code - s : m_code + s;
                if (t < 0)   begin t = 0;   m_sat = 1; end
                if (t > NSW) begin t = NSW; m_sat = 1; end
                m_code = t;
                m_left = 8;
            end
        end else begin
            if (upd && m_drop < 255) m_drop++;
            m_left--;
        end
        e.code = m_code; e.bsy = (m_left != 0); e.sat = m_sat; e.drop = m_drop;
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        bit u, d, l, r;

        // reset and coarse raise-frequency steps
        vec(1,0,0,0,16,0,0,0); vec(0,0,0,0,16,0,0,0);
        vec(0,1,1,0,12,1,0,0); settle(12,0);
        vec(0,1,1,0, 8,1,0,0);
        vec(0,0,0,0, 8,1,0,0); vec(0,0,0,0, 8,1,0,0);
        vec(0,1,1,0, 8,1,0,1);                          // dropped
        for (int i = 0; i < 4; i++) vec(0,0,0,0,8,1,0,1);
        vec(0,0,0,0, 8,0,0,1);
        vec(0,1,1,0, 4,1,0,1); settle(4,1);
        // upper saturation
        vec(1,0,0,0,16,0,0,0);
        vec(0,1,0,0,20,1,0,0); settle(20,0);
        vec(0,1,0,0,24,1,0,0); settle(24,0);
        vec(0,1,0,0,28,1,0,0); settle(28,0);
        vec(0,1,0,1,29,1,0,0); settle(29,0);
        vec(0,1,0,1,30,1,0,0); settle(30,0);
        vec(0,1,0,0,32,1,1,0); settle(32,0);
        vec(0,1,0,0,32,1,1,0); settle(32,0);
        // lower saturation with fine steps
        vec(1,0,0,0,16,0,0,0);
        vec(0,1,1,0,12,1,0,0); settle(12,0);
        vec(0,1,1,0, 8,1,0,0); settle(8,0);
        vec(0,1,1,0, 4,1,0,0); settle(4,0);
        vec(0,1,1,1, 3,1,0,0); settle(3,0);
        vec(0,1,1,1, 2,1,0,0); settle(2,0);
        vec(0,1,1,1, 1,1,0,0); settle(1,0);
        vec(0,1,1,1, 0,1,0,0); settle(0,0);
        vec(0,1,1,1, 0,1,1,0); settle(0,0);
        // lock change mid-window, drop on the timer-expiry edge
        vec(0,1,0,0, 4,1,0,0);
        for (int i = 0; i < 7; i++) vec(0,0,0,1,4,1,0,0);
        vec(0,1,0,1, 4,0,0,1);
        vec(0,1,0,1, 5,1,0,1); settle(5,1);
        // reset in the middle of a settle window
        vec(1,0,0,0,16,0,0,0);
        vec(0,1,0,0,20,1,0,0);
        vec(0,0,0,0,20,1,0,0);
        vec(0,1,1,0,20,1,0,1);
        vec(0,0,0,0,20,1,0,1);
        vec(1,1,0,0,16,0,0,0);
        vec(0,0,0,0,16,0,0,0);
        vec(0,1,1,0,12,1,0,0); settle(12,0);

        foreach (tbl[k]) begin
            e.code = tbl[k].code; e.bsy = tbl[k].bsy;
            e.sat  = tbl[k].sat;  e.drop = tbl[k].drop;
            sb_q.push_back(e);
            apply(tbl[k].rst, tbl[k].upd, tbl[k].dir, tbl[k].lk);
        end

        // random phase against the model; dense requests push drop_cnt to 255
        model_step(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        for (int n = 0; n < 700; n++) begin
            r = ($urandom_range(0, 299) == 0);
            u = ($urandom_range(0, 9) != 0);
            d = $urandom_range(0, 1) != 0;
            l = ($urandom_range(0, 3) == 0);
            model_step(r, u, d, l);
            apply(r, u, d, l);
        end
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
